// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: operation encodings, default latencies and the
// control-state type used by the E-stage multiply/divide unit.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle MULT/DIV with architectural HI/LO,
// plus MFHI/MFLO read-out and MTHI/MTLO writes.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [3:0]        op_reg, op_next;
  logic [31:0]       a_reg, a_next;
  logic [31:0]       b_reg, b_next;
  logic [31:0]       hi_reg, hi_next;
  logic [31:0]       lo_reg, lo_next;

  logic [63:0] prod_u, prod_s;
  logic        signed_div, a_neg, b_neg, div_by_zero;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
  logic [31:0] res_hi, res_lo;

  assign prod_u = {32'd0, a_reg} * {32'd0, b_reg};
  assign prod_s = $signed({{32{a_reg[31]}}, a_reg}) * $signed({{32{b_reg[31]}}, b_reg});

  // Divide on magnitudes, then restore signs; this also yields the wrapped
  // 0x80000000 quotient for 0x80000000 / -1 without a special case.
  assign signed_div  = (op_reg == MDU_DIV);
  assign a_neg       = signed_div & a_reg[31];
  assign b_neg       = signed_div & b_reg[31];
  assign a_mag       = a_neg ? (32'd0 - a_reg) : a_reg;
  assign b_mag       = b_neg ? (32'd0 - b_reg) : b_reg;
  assign div_by_zero = (b_reg == 32'd0);
  assign b_safe      = div_by_zero ? 32'd1 : b_mag;
  assign q_mag       = a_mag / b_safe;
  assign r_mag       = a_mag % b_safe;
  assign quot        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem         = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    res_hi = hi_reg;
    res_lo = lo_reg;
    case (op_reg)
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_DIV, MDU_DIVU: begin
        if (!div_by_zero) begin
          res_hi = rem;
          res_lo = quot;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    case (state_reg)
      MDU_IDLE: begin
        if (start && !flush && is_muldiv(mdu_op)) begin
          state_next = MDU_BUSY;
          op_next    = mdu_op;
          a_next     = rs_data;
          b_next     = rt_data;
          cnt_next   = ((mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU)) ?
                       CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (!flush && (mdu_op == MDU_MTHI)) begin
          hi_next = rs_data;
        end else if (!flush && (mdu_op == MDU_MTLO)) begin
          lo_next = rs_data;
        end
      end
      MDU_BUSY: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = MDU_IDLE;
          hi_next    = res_hi;
          lo_next    = res_lo;
        end
      end
      default: state_next = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= MDU_IDLE;
      cnt_reg   <= '0;
      op_reg    <= MDU_NONE;
      a_reg     <= '0;
      b_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  assign busy      = (state_reg == MDU_BUSY);
  assign stall_req = busy | (start & ~flush);
  assign hi        = hi_reg;
  assign lo        = lo_reg;
  assign mdu_out   = (mdu_op == MDU_MFHI) ? hi_reg :
                     (mdu_op == MDU_MFLO) ? lo_reg : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Randomized and directed bench for e_mdu, compared every cycle against a
// timestamp-based behavioural model of HI/LO and the busy window.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  mdu_op = 4'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        flush = 1'b0;
  logic        busy, stall_req;
  logic [31:0] hi, lo, mdu_out;

  int checks = 0;
  int failures = 0;

  e_mdu dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo), .mdu_out(mdu_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic in 64-bit integers, returns {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (op)
      MDU_MULT:  return 64'(sa * sb);
      MDU_MULTU: return ua * ub;
      MDU_DIV: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        q = longint'(ua / ub);
        r = longint'(ua % ub);
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Model: an accepted op is due at edge number done_at; until then HI/LO hold.
  int          cyc = 0;
  int          done_at = 0;
  bit          m_active = 0;
  bit          m_nowrite = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pending = '0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_hi = '0;
      m_lo = '0;
      m_active = 0;
    end else if (m_active) begin
      if (cyc == done_at) begin
        m_active = 0;
        if (!m_nowrite) {m_hi, m_lo} = m_pending;
      end
    end else if (start && !flush && mdu_op >= 4'd1 && mdu_op <= 4'd4) begin
      m_active  = 1;
      done_at   = cyc + ((mdu_op <= 4'd2) ? 5 : 10);
      m_nowrite = (mdu_op >= 4'd3) && (rt_data == 32'd0);
      if (!m_nowrite) m_pending = ref_result(mdu_op, rs_data, rt_data);
    end else if (!flush && mdu_op == MDU_MTHI) begin
      m_hi = rs_data;
    end else if (!flush && mdu_op == MDU_MTLO) begin
      m_lo = rs_data;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("cmp_busy", 32'(busy), 32'(m_active));
      chk("cmp_hi", hi, m_hi);
      chk("cmp_lo", lo, m_lo);
      chk("cmp_stall", 32'(stall_req), 32'(m_active || (start && !flush)));
      chk("cmp_mdu_out", mdu_out,
          (mdu_op == MDU_MFHI) ? m_hi : (mdu_op == MDU_MFLO) ? m_lo : 32'd0);
    end
  end

  task automatic step(input logic st, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic fl);
    start = st;
    mdu_op = op;
    rs_data = a;
    rt_data = b;
    flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, MDU_NONE, 32'd0, 32'd0, 1'b0);
  endtask

  // Starts an op, then counts busy cycles (bounded) while rs/rt wander.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc);
    int n;
    n = 0;
    step(1'b1, op, a, b, 1'b0);
    while (busy && n < 40) begin
      step(1'b0, MDU_NONE, $urandom, $urandom, 1'b0);
      n++;
    end
    chk({name, "_busy_cycles"}, 32'(n), 32'(exp_cyc));
    $display("op %s rs=%h rt=%h -> hi=%h lo=%h after %0d busy cycles", name, a, b, hi, lo, n);
  endtask

  initial begin
    int n;
    logic [3:0] op;
    logic [31:0] a, b;

    idle(2);
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    run_op("MULT", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    run_op("MULTU", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 5);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);
    run_op("DIV", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    run_op("DIVU", MDU_DIVU, 32'd7, 32'd2, 10);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    run_op("DIV_OVF", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'd0);

    step(1'b0, MDU_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    chk("mthi_hi", hi, 32'h1234_5678);
    mdu_op = MDU_MFHI;
    #1;
    chk("mfhi_out", mdu_out, 32'h1234_5678);
    $display("op MTHI/MFHI -> hi=%h mdu_out=%h", hi, mdu_out);
    step(1'b0, MDU_MTLO, 32'd9, 32'd0, 1'b0);
    step(1'b1, MDU_MULT, 32'd4, 32'd5, 1'b0);
    step(1'b0, MDU_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0);
    chk("mtlo_busy_lo", lo, 32'd9);
    $display("op MTLO while busy -> lo=%h", lo);
    idle(6);
    chk("mult_after_mtlo_lo", lo, 32'd20);

    step(1'b0, MDU_MTHI, 32'hA, 32'd0, 1'b0);
    step(1'b0, MDU_MTLO, 32'hB, 32'd0, 1'b0);
    run_op("DIV0", MDU_DIV, 32'd5, 32'd0, 10);
    chk("div0_hi", hi, 32'hA);
    chk("div0_lo", lo, 32'hB);

    step(1'b1, MDU_MULT, 32'd7, 32'd7, 1'b0);
    idle(2);
    reset = 1'b1;
    idle(1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("rst_after_hilo", hi | lo, 32'd0);
    end
    $display("op reset mid-MULT -> busy=%b hi=%h lo=%h", busy, hi, lo);

    start = 1'b1;
    mdu_op = MDU_MULT;
    rs_data = 32'd3;
    rt_data = 32'd3;
    flush = 1'b1;
    #1;
    chk("flush_stall", 32'(stall_req), 32'd0);
    @(posedge clk);
    #1;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_lo", lo, 32'd0);
    $display("op MULT flushed -> busy=%b lo=%h", busy, lo);

    step(1'b1, MDU_MULT, 32'd2, 32'd3, 1'b0);
    step(1'b1, MDU_MULT, 32'd100, 32'd100, 1'b0);
    n = 1;
    while (busy && n < 40) begin
      idle(1);
      n++;
    end
    chk("restart_busy_cycles", 32'(n), 32'd5);
    chk("restart_lo", lo, 32'd6);
    $display("op start while busy -> lo=%h after %0d busy cycles", lo, n);

    for (int i = 0; i < 600; i++) begin
      op = 4'($urandom_range(0, 8));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 15) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
      reset = ($urandom_range(0, 59) == 0);
      step((op >= 4'd1 && op <= 4'd4) ? 1'($urandom_range(0, 1)) : 1'b0, op, a, b,
           ($urandom_range(0, 7) == 0));
      if (i % 50 == 0)
        $display("random cycle %0d op=%0d rs=%h rt=%h -> busy=%b hi=%h lo=%h",
                 i, op, a, b, busy, hi, lo);
    end
    reset = 1'b0;
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for DIV/DIVU.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 start  input  1  E-stage instruction is MULT/MULTU/DIV/DIVU this cycle.
REQ-006 mdu_op  input  4  operation code: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
REQ-007 rs_data  input  32  forwarded rs operand (multiplicand/dividend/MT source).
REQ-008 rt_data  input  32  forwarded rt operand (multiplier/divisor).
REQ-009 flush  input  1  kill E-stage instruction; start/MTHI/MTLO suppressed this cycle.
REQ-010 busy  output  1  operation in progress; registered.
REQ-011 stall_req  output  1  busy OR (start AND NOT flush); drives hazard-unit stall of MDU instructions in D.
REQ-012 hi  output  32  architectural HI register.
REQ-013 lo  output  32  architectural LO register.
REQ-014 mdu_out  output  32  hi when mdu_op=MFHI, lo when MFLO, else 0; combinational, feeds E_MDUAns.

Function
REQ-015 Idle: start=1 with a valid mult/div op and flush=0 latches operands and op, loads counter with MULT_CYCLES or DIV_CYCLES, sets busy next edge.
REQ-016 Busy: counter decrements each cycle; on the edge where the counter reaches 0, HI/LO are written and busy clears; total busy high cycles equal the parameter value.
REQ-017 HI/LO hold previous values during busy; new values visible the cycle busy first reads 0.
REQ-018 MULT: {hi,lo} = signed 32x32 -> 64 product; MULTU: unsigned product.
REQ-019 DIV: lo = quotient truncated toward zero, hi = remainder with sign of dividend; DIVU: unsigned quotient/remainder.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
REQ-021 Divisor 0 (DIV or DIVU): full busy period elapses, HI/LO unchanged.
REQ-022 start asserted while busy: ignored, in-flight operation unaffected (hazard unit guarantees this does not occur legally).
REQ-023 MTHI/MTLO while idle and flush=0: hi (resp. lo) <= rs_data at next edge; while busy: ignored.
REQ-024 MFHI/MFLO while busy return the pre-operation value (hazard unit stalls them).
REQ-025 flush=1: no new operation starts and no MT write; an operation already busy continues to completion.
REQ-026 Result computed from latched operands only; rs_data/rt_data changes during busy have no effect.

Reset
REQ-027 reset=1 at a rising edge: hi=0, lo=0, busy=0, counter=0, latched operands=0, takes priority over start/MT/completion.
REQ-028 reset mid-operation aborts it; no HI/LO write occurs after reset deasserts.
REQ-029 stall_req=0 and mdu_out=0 combinationally whenever busy=0 and start=0 and op not MF*.

Structure
REQ-030 mdu_op encodings and MULT_CYCLES/DIV_CYCLES defaults live in the shared definitions header alongside the existing opcode constants.
REQ-031 Single module, no sub-module; two-state control (IDLE, BUSY) plus down-counter, result computed combinationally from latched operands and written at completion.
REQ-032 mdu_out connects directly to the E_MDUAns input of the E/M pipeline register.

Verification
REQ-033 MULT rs=0xFFFFFFFE(-2), rt=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-034 DIV rs=0xFFFFFFF9(-7), rt=2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
REQ-035 MTHI rs=0x12345678 idle -> hi=0x12345678 next cycle; MFHI -> mdu_out=0x12345678; MTLO during busy -> lo unchanged.
REQ-036 DIV rs=5, rt=0 with hi=0xA, lo=0xB -> busy 10 cycles, hi=0xA, lo=0xB after.
REQ-037 reset asserted at cycle 3 of a MULT -> busy=0, hi=lo=0 immediately, remain 0 for following 10 cycles.
REQ-038 start with flush=1 -> busy stays 0, stall_req=0, hi/lo unchanged; start while busy -> original result written at original completion cycle.
